// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase controller.
// Pure definitions: no logic, no latency, no flow control.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    EW_G  = 3'd2,
    EW_Y  = 3'd3,
    FLASH = 3'd4
  } state_t;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam logic [2:0] LIGHT_OFF = 3'b000;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // Elaboration-time only: turns a 0..99 parameter into two BCD digits.
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/traffic_countdown_bcd_down2.sv
// Two-digit BCD down counter, synchronous load wins over decrement.
// Count visible one cycle after load/dec; no flow control.
module bcd_down2 #(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk_500,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] cnt
);

  always_ff @(posedge clk_500) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      if (cnt[3:0] == 4'd0) begin
        cnt <= {cnt[7:4] - 4'd1, 4'd9};
      end else begin
        cnt[3:0] <= cnt[3:0] - 4'd1;
      end
    end
  end

endmodule

// File: rtl/traffic_countdown.sv
// Intersection phase FSM plus per-direction BCD countdowns; night flashing with NIGHT_MODE_EN.
// Outputs registered one cycle after the internal change; no backpressure.
module traffic_countdown
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 500,
  parameter int NS_GREEN = 25,
  parameter int EW_GREEN = 20,
  parameter int YELLOW   = 3
) (
  input  logic       clk_500,
  input  logic       rst,
`ifdef NIGHT_MODE_EN
  input  logic       night,
`endif
  output logic [3:0] fir,
  output logic [3:0] sec,
  output logic [3:0] thi,
  output logic [3:0] fou,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0] NSG_BCD = to_bcd(NS_GREEN);
  localparam logic [7:0] NSR_BCD = to_bcd(NS_GREEN + YELLOW);
  localparam logic [7:0] EWG_BCD = to_bcd(EW_GREEN);
  localparam logic [7:0] EWR_BCD = to_bcd(EW_GREEN + YELLOW);
  localparam logic [7:0] YEL_BCD = to_bcd(YELLOW);

  state_t state, state_nxt;
  logic [DIV_W-1:0] div;
  logic tick, div_clr, flash_on;
  logic ns_load, ew_load, ns_dec, ew_dec;
  logic [7:0] ns_load_val, ew_load_val, ns_cnt, ew_cnt;
  logic [2:0] ns_light_d, ew_light_d;
  logic [15:0] digits_d;

  assign tick = (div == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk_500) begin
    if (rst || div_clr || tick) div <= '0;
    else                        div <= div + DIV_W'(1);
  end

  always_ff @(posedge clk_500) begin
    if (rst) state <= NS_G;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    div_clr     = 1'b0;
    ns_load     = 1'b0;
    ew_load     = 1'b0;
    ns_dec      = 1'b0;
    ew_dec      = 1'b0;
    ns_load_val = NSG_BCD;
    ew_load_val = NSR_BCD;
    case (state)
      NS_G: if (tick) begin
        if (ns_cnt == 8'h01) begin
          state_nxt   = NS_Y;
          ns_load     = 1'b1;
          ns_load_val = YEL_BCD;
          ew_dec      = 1'b1;
        end else begin
          ns_dec = 1'b1;
          ew_dec = 1'b1;
        end
      end
      NS_Y: if (tick) begin
        if (ns_cnt == 8'h01) begin
          state_nxt   = EW_G;
          ns_load     = 1'b1;
          ew_load     = 1'b1;
          ns_load_val = EWR_BCD;
          ew_load_val = EWG_BCD;
        end else begin
          ns_dec = 1'b1;
          ew_dec = 1'b1;
        end
      end
      EW_G: if (tick) begin
        if (ew_cnt == 8'h01) begin
          state_nxt   = EW_Y;
          ew_load     = 1'b1;
          ew_load_val = YEL_BCD;
          ns_dec      = 1'b1;
        end else begin
          ns_dec = 1'b1;
          ew_dec = 1'b1;
        end
      end
      EW_Y: if (tick) begin
        if (ew_cnt == 8'h01) begin
          state_nxt = NS_G;
          ns_load   = 1'b1;
          ew_load   = 1'b1;
        end else begin
          ns_dec = 1'b1;
          ew_dec = 1'b1;
        end
      end
`ifdef NIGHT_MODE_EN
      FLASH: if (!night) begin
        state_nxt = NS_G;
        ns_load   = 1'b1;
        ew_load   = 1'b1;
        div_clr   = 1'b1;
      end
`endif
      default: begin
        state_nxt = NS_G;
        ns_load   = 1'b1;
        ew_load   = 1'b1;
        div_clr   = 1'b1;
      end
    endcase
`ifdef NIGHT_MODE_EN
    // Night request overrides whatever the phase logic decided.
    if (night && state != FLASH) begin
      state_nxt = FLASH;
      div_clr   = 1'b1;
      ns_load   = 1'b0;
      ew_load   = 1'b0;
      ns_dec    = 1'b0;
      ew_dec    = 1'b0;
    end
`endif
  end

`ifdef NIGHT_MODE_EN
  always_ff @(posedge clk_500) begin
    if (rst)                                    flash_on <= 1'b0;
    else if (state_nxt == FLASH && state != FLASH) flash_on <= 1'b1;
    else if (state == FLASH && tick)            flash_on <= ~flash_on;
  end
`else
  assign flash_on = 1'b0;
`endif

  bcd_down2 #(.RST_VAL(NSG_BCD)) u_ns_cnt (
    .clk_500 (clk_500),
    .rst     (rst),
    .load    (ns_load),
    .load_val(ns_load_val),
    .dec     (ns_dec),
    .cnt     (ns_cnt)
  );

  bcd_down2 #(.RST_VAL(NSR_BCD)) u_ew_cnt (
    .clk_500 (clk_500),
    .rst     (rst),
    .load    (ew_load),
    .load_val(ew_load_val),
    .dec     (ew_dec),
    .cnt     (ew_cnt)
  );

  always_comb begin
    ns_light_d = LIGHT_GRN;
    ew_light_d = LIGHT_RED;
    digits_d   = {ns_cnt, ew_cnt};
    case (state)
      NS_G: begin end
      NS_Y: ns_light_d = LIGHT_YEL;
      EW_G: begin
        ns_light_d = LIGHT_RED;
        ew_light_d = LIGHT_GRN;
      end
      EW_Y: begin
        ns_light_d = LIGHT_RED;
        ew_light_d = LIGHT_YEL;
      end
      default: begin
        ns_light_d = flash_on ? LIGHT_YEL : LIGHT_OFF;
        ew_light_d = flash_on ? LIGHT_YEL : LIGHT_OFF;
        digits_d   = {4{DIGIT_BLANK}};
      end
    endcase
  end

  always_ff @(posedge clk_500) begin
    if (rst) begin
      {fir, sec} <= NSG_BCD;
      {thi, fou} <= NSR_BCD;
      ns_light   <= LIGHT_GRN;
      ew_light   <= LIGHT_RED;
    end else begin
      {fir, sec, thi, fou} <= digits_d;
      ns_light             <= ns_light_d;
      ew_light             <= ew_light_d;
    end
  end

endmodule

// File: tb/tb_traffic_countdown.sv
// Bench for traffic_countdown: closed-form timeline model compared every cycle, plus literal pins.
module tb_traffic_countdown;

  localparam int TD = 4;

  typedef struct packed {
    logic [3:0] fir, sec, thi, fou;
    logic [2:0] nl, el;
  } obs_t;

  logic clk_500 = 1'b0;
  logic rst = 1'b1;
  logic night = 1'b0;
  logic [3:0] fir1, sec1, thi1, fou1, fir2, sec2, thi2, fou2;
  logic [2:0] nl1, el1, nl2, el2;
  obs_t act1, act2;
  assign act1 = {fir1, sec1, thi1, fou1, nl1, el1};
  assign act2 = {fir2, sec2, thi2, fou2, nl2, el2};

  int checks = 0;
  int errors = 0;

  always #5 clk_500 = ~clk_500;

  traffic_countdown #(.TICK_DIV(TD), .NS_GREEN(5), .EW_GREEN(4), .YELLOW(2)) dut (
    .clk_500(clk_500), .rst(rst),
`ifdef NIGHT_MODE_EN
    .night(night),
`endif
    .fir(fir1), .sec(sec1), .thi(thi1), .fou(fou1), .ns_light(nl1), .ew_light(el1));

  traffic_countdown #(.TICK_DIV(TD), .NS_GREEN(12), .EW_GREEN(4), .YELLOW(2)) dut2 (
    .clk_500(clk_500), .rst(rst),
`ifdef NIGHT_MODE_EN
    .night(1'b0),
`endif
    .fir(fir2), .sec(sec2), .thi(thi2), .fou(fou2), .ns_light(nl2), .ew_light(el2));

  function automatic obs_t mk(int a, int b, int c, int d, logic [2:0] nl, logic [2:0] el);
    return {4'(a), 4'(b), 4'(c), 4'(d), nl, el};
  endfunction

  // Expected display after m cycles since a fresh NS green start, from the phase timeline.
  function automatic obs_t normal(int m, int ng, int eg, int y);
    int k, p, q, ns, ew;
    logic [2:0] nl, el;
    k = m / TD;
    p = k % (ng + eg + 2 * y);
    if (p < ng) begin
      ns = ng - p; ew = ng + y - p; nl = 3'b001; el = 3'b100;
    end else if (p < ng + y) begin
      ns = ng + y - p; ew = ns; nl = 3'b010; el = 3'b100;
    end else if (p < ng + y + eg) begin
      q = p - ng - y; ew = eg - q; ns = eg + y - q; nl = 3'b100; el = 3'b001;
    end else begin
      q = p - ng - y; ew = eg + y - q; ns = ew; nl = 3'b100; el = 3'b010;
    end
    return mk(ns / 10, ns % 10, ew / 10, ew % 10, nl, el);
  endfunction

  function automatic obs_t flash_obs(int fm);
    logic [2:0] l;
    l = ((fm / TD) % 2 == 0) ? 3'b010 : 3'b000;
    return mk(15, 15, 15, 15, l, l);
  endfunction

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // Model: internal state after each edge; the registered outputs show it one edge later.
  obs_t int1, int2, vis1, vis2;
  int m1 = 0, m2 = 0, fm = 0;
  bit flash = 0, valid = 0;

  always @(posedge clk_500) begin
    vis1 = int1;
    vis2 = int2;
    if (rst) begin
      m1 = 0; m2 = 0; flash = 0; valid = 1;
      int1 = normal(0, 5, 4, 2);
      int2 = normal(0, 12, 4, 2);
      vis1 = int1;
      vis2 = int2;
    end else begin
      m2++;
      int2 = normal(m2, 12, 4, 2);
      if (night && !flash) begin
        flash = 1; fm = 0; int1 = flash_obs(0);
      end else if (flash && !night) begin
        flash = 0; m1 = 0; int1 = normal(0, 5, 4, 2);
      end else if (flash) begin
        fm++; int1 = flash_obs(fm);
      end else begin
        m1++; int1 = normal(m1, 5, 4, 2);
      end
    end
  end

  always @(negedge clk_500) begin
    if (valid) begin
      chk("model_main", act1, vis1);
      chk("model_borrow", act2, vis2);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_500);
  endtask

  initial begin
    step(3);
    rst = 0;
    step(1);  chk("reset_release", act1, mk(0, 5, 0, 7, 3'b001, 3'b100));
    step(4);  chk("first_dec", act1, mk(0, 4, 0, 6, 3'b001, 3'b100));
    step(4);  chk("borrow_10", act2, mk(1, 0, 1, 2, 3'b001, 3'b100));
    step(4);  chk("borrow_09", act2, mk(0, 9, 1, 1, 3'b001, 3'b100));
    step(8);  chk("ns_yellow", act1, mk(0, 2, 0, 2, 3'b010, 3'b100));
    step(8);  chk("ew_green", act1, mk(0, 6, 0, 4, 3'b100, 3'b001));
    step(24); chk("full_cycle", act1, mk(0, 5, 0, 7, 3'b001, 3'b100));
    step(149);
    chk("ew_yellow_pre_rst", act1, mk(0, 2, 0, 2, 3'b100, 3'b010));
    rst = 1;
    step(1);  chk("mid_reset", act1, mk(0, 5, 0, 7, 3'b001, 3'b100));
    rst = 0;
    step(4);  chk("no_early_tick", act1, mk(0, 5, 0, 7, 3'b001, 3'b100));
    step(1);  chk("tick_after_rst", act1, mk(0, 4, 0, 6, 3'b001, 3'b100));
`ifdef NIGHT_MODE_EN
    step(5);
    night = 1;
    step(2);  chk("flash_on", act1, mk(15, 15, 15, 15, 3'b010, 3'b010));
    step(4);  chk("flash_off", act1, mk(15, 15, 15, 15, 3'b000, 3'b000));
    step(4);  chk("flash_on2", act1, mk(15, 15, 15, 15, 3'b010, 3'b010));
    step(1);
    night = 0;
    step(2);  chk("night_exit", act1, mk(0, 5, 0, 7, 3'b001, 3'b100));
`endif
    step(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
